// File: rtl/led_pkg.sv
// Shared constants and types for the LED frame sequencer and its RAM arbiter.
package led_pkg;

    localparam int unsigned RAM_ADDR_W    = 9;
    localparam int unsigned RAM_DATA_W    = 8;
    localparam int unsigned RAM_DEPTH     = 512;
    localparam int unsigned BYTES_PER_LED = 3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

    // Requester that wins a contested cycle given the previous winner.
    function automatic grant_e rr_pick(input grant_e last);
        grant_e pick;
        if (last == GRANT_READ) pick = GRANT_WRITE;
        else                    pick = GRANT_READ;
        return pick;
    endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Bundles the frame control, byte stream, host write and RAM port signals of the sequencer.
interface led_frame_sequencer_if;
    import led_pkg::*;

    logic                  frame_start;
    logic                  busy;
    logic                  frame_done;
    logic [RAM_DATA_W-1:0] byte_data;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  wr_req;
    logic [RAM_ADDR_W-1:0] wr_addr;
    logic [RAM_DATA_W-1:0] wr_data;
    logic                  wr_ack;
    logic                  mem_perform_read;
    logic [RAM_ADDR_W-1:0] mem_read_address;
    logic [RAM_DATA_W-1:0] mem_read_data;
    logic                  mem_perform_write;
    logic [RAM_ADDR_W-1:0] mem_write_address;
    logic [RAM_DATA_W-1:0] mem_write_data;

    // Environment side: host, serializer and RAM.
    modport master (
        output frame_start, byte_ready, wr_req, wr_addr, wr_data, mem_read_data,
        input  busy, frame_done, byte_data, byte_valid, wr_ack,
        input  mem_perform_read, mem_read_address,
        input  mem_perform_write, mem_write_address, mem_write_data
    );

    // Sequencer side.
    modport slave (
        input  frame_start, byte_ready, wr_req, wr_addr, wr_data, mem_read_data,
        output busy, frame_done, byte_data, byte_valid, wr_ack,
        output mem_perform_read, mem_read_address,
        output mem_perform_write, mem_write_address, mem_write_data
    );

endinterface

// File: rtl/led_ram_arbiter.sv
// Two-requester round-robin arbiter for the frame RAM with registered grants and port muxing.
module led_ram_arbiter
    import led_pkg::*;
(
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rd_req,
    input  logic [RAM_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_wr_req,
    input  logic [RAM_ADDR_W-1:0] i_wr_addr,
    input  logic [RAM_DATA_W-1:0] i_wr_data,
    output logic                  o_mem_perform_read,
    output logic [RAM_ADDR_W-1:0] o_mem_read_address,
    output logic                  o_mem_perform_write,
    output logic [RAM_ADDR_W-1:0] o_mem_write_address,
    output logic [RAM_DATA_W-1:0] o_mem_write_data
);

    logic                  r_perform_read;
    logic                  r_perform_write;
    logic [RAM_ADDR_W-1:0] r_read_address;
    logic [RAM_ADDR_W-1:0] r_write_address;
    logic [RAM_DATA_W-1:0] r_write_data;
    grant_e                r_last_grant;

    logic w_rd_req;
    logic w_wr_req;
    logic w_grant_rd;
    logic w_grant_wr;

    // A request already granted is still held by its owner during the grant cycle; mask it.
    assign w_rd_req = i_rd_req && !r_perform_read;
    assign w_wr_req = i_wr_req && !r_perform_write;

    always_comb begin
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        if (w_rd_req && w_wr_req) begin
            if (rr_pick(r_last_grant) == GRANT_READ) w_grant_rd = 1'b1;
            else                                     w_grant_wr = 1'b1;
        end else begin
            w_grant_rd = w_rd_req;
            w_grant_wr = w_wr_req;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_perform_read  <= 1'b0;
            r_perform_write <= 1'b0;
            r_read_address  <= '0;
            r_write_address <= '0;
            r_write_data    <= '0;
            r_last_grant    <= GRANT_READ;
        end else begin
            r_perform_read  <= w_grant_rd;
            r_perform_write <= w_grant_wr;
            if (w_grant_rd) begin
                r_read_address <= i_rd_addr;
                r_last_grant   <= GRANT_READ;
            end else if (w_grant_wr) begin
                r_last_grant   <= GRANT_WRITE;
            end
            if (w_grant_wr) begin
                r_write_address <= i_wr_addr;
                r_write_data    <= i_wr_data;
            end
        end
    end

    assign o_mem_perform_read  = r_perform_read;
    assign o_mem_read_address  = r_read_address;
    assign o_mem_perform_write = r_perform_write;
    assign o_mem_write_address = r_write_address;
    assign o_mem_write_data    = r_write_data;

endmodule

// File: rtl/led_frame_sequencer.sv
// Streams one LED frame (GRB bytes) from the shared frame RAM to the serializer per frame_start,
// sharing the RAM port with host writes through a round-robin arbiter.
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int unsigned LED_COUNT = 160,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    led_frame_sequencer_if.slave  bus
);

    localparam int unsigned           FRAME_BYTES = LED_COUNT * BYTES_PER_LED;
    localparam logic [RAM_ADDR_W-1:0] LAST_IDX    = RAM_ADDR_W'(FRAME_BYTES - 1);
    localparam logic [RAM_ADDR_W-1:0] BASE        = RAM_ADDR_W'(BASE_ADDR);

    if (LED_COUNT == 0 || FRAME_BYTES + BASE_ADDR > RAM_DEPTH) begin : g_bad_size
        $error("led_frame_sequencer: frame does not fit in the 512-byte RAM");
    end

    logic [2:0]            r_state;
    logic [RAM_ADDR_W-1:0] r_count;
    logic                  r_busy;
    logic                  r_frame_done;
    logic [RAM_DATA_W-1:0] r_byte_data;
    logic                  r_byte_valid;

    logic [2:0]            w_state_d;
    logic [RAM_ADDR_W-1:0] w_count_d;
    logic                  w_busy_d;
    logic                  w_frame_done_d;
    logic [RAM_DATA_W-1:0] w_byte_data_d;
    logic                  w_byte_valid_d;

    logic                  w_rd_req;
    logic [RAM_ADDR_W-1:0] w_rd_addr;
    logic                  w_mem_perform_read;
    logic [RAM_ADDR_W-1:0] w_mem_read_address;
    logic                  w_mem_perform_write;
    logic [RAM_ADDR_W-1:0] w_mem_write_address;
    logic [RAM_DATA_W-1:0] w_mem_write_data;

    assign w_rd_req  = (r_state == ST_REQ);
    assign w_rd_addr = BASE + r_count;

    always_comb begin
        w_state_d      = r_state;
        w_count_d      = r_count;
        w_busy_d       = r_busy;
        w_frame_done_d = 1'b0;
        w_byte_data_d  = r_byte_data;
        w_byte_valid_d = r_byte_valid;
        case (r_state)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    w_count_d = '0;
                    w_busy_d  = 1'b1;
                    w_state_d = ST_REQ;
                end
            end
            // The read enable is registered in the arbiter; its high cycle marks the grant.
            ST_REQ: begin
                if (w_mem_perform_read) w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
                w_byte_data_d  = bus.mem_read_data;
                w_byte_valid_d = 1'b1;
                w_state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_byte_valid && bus.byte_ready) begin
                    w_byte_valid_d = 1'b0;
                    if (r_count == LAST_IDX) begin
                        w_frame_done_d = 1'b1;
                        w_state_d      = ST_DONE;
                    end else begin
                        w_count_d = r_count + 1'b1;
                        w_state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                w_busy_d  = 1'b0;
                w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_count      <= w_count_d;
            r_busy       <= w_busy_d;
            r_frame_done <= w_frame_done_d;
            r_byte_data  <= w_byte_data_d;
            r_byte_valid <= w_byte_valid_d;
        end
    end

    led_ram_arbiter u_arbiter (
        .i_clock             (i_clock),
        .i_reset             (i_reset),
        .i_rd_req            (w_rd_req),
        .i_rd_addr           (w_rd_addr),
        .i_wr_req            (bus.wr_req),
        .i_wr_addr           (bus.wr_addr),
        .i_wr_data           (bus.wr_data),
        .o_mem_perform_read  (w_mem_perform_read),
        .o_mem_read_address  (w_mem_read_address),
        .o_mem_perform_write (w_mem_perform_write),
        .o_mem_write_address (w_mem_write_address),
        .o_mem_write_data    (w_mem_write_data)
    );

    assign bus.busy              = r_busy;
    assign bus.frame_done        = r_frame_done;
    assign bus.byte_data         = r_byte_data;
    assign bus.byte_valid        = r_byte_valid;
    assign bus.wr_ack            = w_mem_perform_write;
    assign bus.mem_perform_read  = w_mem_perform_read;
    assign bus.mem_read_address  = w_mem_read_address;
    assign bus.mem_perform_write = w_mem_perform_write;
    assign bus.mem_write_address = w_mem_write_address;
    assign bus.mem_write_data    = w_mem_write_data;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench for led_frame_sequencer with LED_COUNT=2 and a behavioural 512x8 RAM.
module tb_led_frame_sequencer;
    import led_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    led_frame_sequencer_if bus();

    led_frame_sequencer #(
        .LED_COUNT (2),
        .BASE_ADDR (0)
    ) dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    // Synchronous RAM: read data appears one clock after the read enable.
    logic [7:0] ram [512];
    logic       tb_we = 1'b0;
    logic [8:0] tb_wa = '0;
    logic [7:0] tb_wd = '0;
    always @(posedge clock) begin
        if (tb_we) ram[tb_wa] <= tb_wd;
        if (bus.mem_perform_write) ram[bus.mem_write_address] <= bus.mem_write_data;
        if (bus.mem_perform_read) bus.mem_read_data <= ram[bus.mem_read_address];
    end

    // Monitor on the falling edge, when inputs and registered outputs are stable.
    logic [7:0] got[$];
    int   fd_cnt = 0, rd_cnt = 0, ack_cnt = 0, both_cnt = 0, ack_consec = 0;
    logic ack_prev = 1'b0;
    always @(negedge clock) begin
        if (bus.byte_valid && bus.byte_ready) got.push_back(bus.byte_data);
        if (bus.frame_done) fd_cnt <= fd_cnt + 1;
        if (bus.mem_perform_read) rd_cnt <= rd_cnt + 1;
        if (bus.wr_ack) ack_cnt <= ack_cnt + 1;
        if (bus.mem_perform_read && bus.mem_perform_write) both_cnt <= both_cnt + 1;
        if (bus.wr_ack && ack_prev) ack_consec <= ack_consec + 1;
        ack_prev <= bus.wr_ack;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (!bus.frame_done && n < max) begin
            tick();
            n++;
        end
        check({name, "_done"}, 64'(bus.frame_done), 64'(1));
        tick();
        check({name, "_busy_after"}, 64'(bus.busy), 64'(0));
    endtask

    logic [7:0] exp_frame [6];

    task automatic check_frame(input string name, input int n0);
        check({name, "_count"}, 64'(got.size() - n0), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (n0 + i < got.size())
                check($sformatf("%s_byte%0d", name, i), 64'(got[n0 + i]), 64'(exp_frame[i]));
        end
    endtask

    typedef struct {
        logic       fs;
        logic       rdy;
        logic       busy;
        logic       valid;
        logic [7:0] data;
        logic       rd;
        logic       fd;
    } vec_t;
    vec_t vecs [26];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, fd0, rd0, ack0, found;

        // Per cycle: one fetch takes REQ, REQ(read enable), WAIT, HOLD.
        // frame_start at vector 10 arrives mid-frame and must be ignored.
        //          fs    rdy   busy  valid data   rd    fd
        vecs[ 0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[ 1] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[ 2] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[ 3] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[ 4] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[ 5] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
        vecs[ 6] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[ 7] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0};
        vecs[ 8] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0};
        vecs[ 9] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h13, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h14, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h14, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h14, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h15, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h15, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h15, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h16, 1'b0, 1'b1};
        vecs[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h16, 1'b0, 1'b0};

        for (int i = 0; i < 6; i++) exp_frame[i] = 8'h11 + 8'(i);

        bus.frame_start = 1'b0;
        bus.byte_ready  = 1'b0;
        bus.wr_req      = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;

        // Preload the frame bytes while reset is held.
        for (int i = 0; i < 6; i++) begin
            tb_we = 1'b1;
            tb_wa = 9'(i);
            tb_wd = 8'h11 + 8'(i);
            tick();
        end
        tb_we = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        check("reset_outputs",
              {bus.busy, bus.frame_done, bus.byte_valid, bus.wr_ack, bus.mem_perform_read,
               bus.mem_perform_write, bus.byte_data, bus.mem_read_address,
               bus.mem_write_address, bus.mem_write_data}, 64'(0));

        // Table-driven first frame with byte_ready held high.
        n0  = got.size();
        fd0 = fd_cnt;
        for (int i = 0; i < 26; i++) begin
            bus.frame_start = vecs[i].fs;
            bus.byte_ready  = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d", i),
                  64'({bus.busy, bus.byte_valid, bus.byte_data, bus.mem_perform_read,
                       bus.frame_done}),
                  64'({vecs[i].busy, vecs[i].valid, vecs[i].data, vecs[i].rd, vecs[i].fd}));
        end
        bus.frame_start = 1'b0;
        check_frame("table", n0);
        check("table_one_done", 64'(fd_cnt - fd0), 64'(1));

        // Serializer stalls five cycles on the third byte.
        n0 = got.size();
        found = 0;
        start_frame();
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (bus.byte_valid && (got.size() - n0 == 2)) found = 1;
            else tick();
        end
        check("stall_reach_byte3", 64'(found), 64'(1));
        bus.byte_ready = 1'b0;
        rd0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_hold%0d", i), 64'({bus.byte_valid, bus.byte_data}),
                  64'({1'b1, 8'h13}));
        end
        check("stall_no_extra_read", 64'(rd_cnt - rd0), 64'(0));
        bus.byte_ready = 1'b1;
        wait_done("stall", 60);
        check_frame("stall", n0);

        // Host write while idle.
        bus.wr_req  = 1'b1;
        bus.wr_addr = 9'h003;
        bus.wr_data = 8'hAA;
        tick();
        check("wr_idle_issue",
              64'({bus.wr_ack, bus.mem_perform_write, bus.mem_write_address, bus.mem_write_data}),
              64'({1'b1, 1'b1, 9'h003, 8'hAA}));
        bus.wr_req = 1'b0;
        tick();
        check("wr_idle_ack_pulse", 64'({bus.wr_ack, bus.mem_perform_write}), 64'(0));
        exp_frame[3] = 8'hAA;
        n0 = got.size();
        start_frame();
        wait_done("after_wr", 60);
        check_frame("after_wr", n0);

        // Write request held for a whole frame, aimed outside the frame bytes.
        bus.wr_req  = 1'b1;
        bus.wr_addr = 9'h100;
        bus.wr_data = 8'h55;
        n0   = got.size();
        rd0  = rd_cnt;
        ack0 = ack_cnt;
        start_frame();
        wait_done("held_wr", 80);
        bus.wr_req = 1'b0;
        tick();
        check_frame("held_wr", n0);
        check("held_wr_reads", 64'(rd_cnt - rd0), 64'(6));
        check("held_wr_ack_many", 64'(ack_cnt - ack0 >= 6), 64'(1));
        check("held_wr_no_back2back_ack", 64'(ack_consec), 64'(0));
        check("never_both_enables", 64'(both_cnt), 64'(0));

        // Reset while a byte is held for the serializer.
        bus.byte_ready = 1'b0;
        found = 0;
        start_frame();
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (bus.byte_valid) found = 1;
            else tick();
        end
        check("rst_reach_hold", 64'(found), 64'(1));
        fd0 = fd_cnt;
        reset = 1'b1;
        #1;
        check("rst_outputs_zero",
              {bus.busy, bus.frame_done, bus.byte_valid, bus.wr_ack, bus.mem_perform_read,
               bus.mem_perform_write, bus.byte_data, bus.mem_read_address,
               bus.mem_write_address, bus.mem_write_data}, 64'(0));
        tick();
        tick();
        reset = 1'b0;
        bus.byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("rst_no_done_idle", 64'({bus.busy, bus.byte_valid, 32'(fd_cnt - fd0)}), 64'(0));
        n0 = got.size();
        start_frame();
        wait_done("rst_restart", 60);
        check_frame("rst_restart", n0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Owns the single 512x8 LED frame RAM port pair. Shares it between a host write requester (SPI/UART command path) and an internal refresh sequencer.
- On each frame_start, the sequencer streams LED_COUNT*3 bytes, GRB order, from BASE_ADDR upward. Bytes go to the downstream LED serializer over a valid/ready handshake. It pulses frame_done at the end.

Parameters:
- LED_COUNT, 160, number of LEDs per frame; LED_COUNT*3 + BASE_ADDR must be <= 512 (elaboration error otherwise).
- BASE_ADDR, 0, first RAM byte address of the frame.

Ports:
- clock  input  1  single system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle request to begin a frame refresh.
- busy  output  1  high from accepted frame_start until the frame_done cycle inclusive.
- frame_done  output  1  one-cycle pulse after the last byte handshake.
- byte_data  output  8  current pixel byte to the serializer.
- byte_valid  output  1  byte_data valid.
- byte_ready  input  1  serializer accepts byte_data.
- wr_req  input  1  host write request, held until wr_ack.
- wr_addr  input  9  host write byte address.
- wr_data  input  8  host write data.
- wr_ack  output  1  one-cycle pulse in the cycle the write is issued to RAM.
- mem_perform_read  output  1  RAM read enable.
- mem_read_address  output  9  RAM read address.
- mem_read_data  input  8  RAM read data, valid one clock after mem_perform_read.
- mem_perform_write  output  1  RAM write enable.
- mem_write_address  output  9  RAM write address.
- mem_write_data  output  8  RAM write data.

Behaviour:
- Reset values: state IDLE; busy, frame_done, byte_valid, wr_ack, mem_perform_read and mem_perform_write are 0; byte_data, the address registers and the byte counter are 0; last_grant = READ.
- Reset mid-frame aborts immediately. No frame_done is issued and no pending write is acked.
- FSM states:
  - IDLE: frame_start=1 clears the counter, sets busy, and moves to REQ. frame_start in any other state is ignored.
  - REQ: raises a read request for address BASE_ADDR+count. When granted, mem_perform_read=1 that cycle and the FSM moves to WAIT.
  - WAIT: captures mem_read_data into byte_data, sets byte_valid=1, and moves to HOLD. Latency from grant to byte_valid is 2 clocks.
  - HOLD: byte_valid held high and byte_data stable until byte_ready=1. On that handshake, byte_valid drops the next cycle and count increments. If count was LED_COUNT*3-1, the FSM goes to DONE; otherwise to REQ.
  - DONE: frame_done=1 for one cycle, busy cleared, then IDLE.
- Arbitration, registered outputs, evaluated each cycle on the current requests (read request = state REQ; write request = wr_req and no wr_ack issued last cycle):
  - Only one request present: grant it.
  - Both present: grant the opposite of last_grant (round-robin). Neither side ever waits more than one cycle.
  - last_grant updates only on a grant.
- A write grant sets mem_perform_write=1, mem_write_address=wr_addr, mem_write_data=wr_data and wr_ack=1 for one cycle. The host must drop or change wr_req after wr_ack; a held wr_req yields the next write 2 cycles later.
- mem_perform_read and mem_perform_write may both be high in one cycle only for different requesters. Round-robin keeps them mutually exclusive, so at most one is high per cycle.
- Writes are accepted in every state, including mid-frame. A write to an already-streamed byte affects the next frame only. A write to the byte currently being read in the same cycle cannot occur (exclusive grant).
- Address width is 9 bits with no wrap. The counter is wide enough for 511 and never exceeds LED_COUNT*3-1.
- byte_ready while byte_valid=0 is ignored.

Decomposition:
- Shared package led_pkg: RAM_ADDR_W=9, RAM_DATA_W=8, BYTES_PER_LED=3, FSM state encoding, grant enum {GRANT_READ, GRANT_WRITE}.
- One sub-module: led_ram_arbiter, a two-requester round-robin with registered grant and RAM-port muxing. The FSM stays in led_frame_sequencer.

Test Plan:
- LED_COUNT=2, RAM preloaded 0x11..0x16 at 0..5, byte_ready tied 1, pulse frame_start -> byte_valid handshakes 0x11,0x12,...,0x16 in order; frame_done pulses once; busy is low the cycle after frame_done.
- Same setup, byte_ready low for 5 cycles on the 3rd byte -> byte_data stays 0x13, byte_valid stays 1, no extra mem_perform_read; stream resumes correctly.
- wr_req with wr_addr=0x003, wr_data=0xAA while idle -> wr_ack and mem_perform_write in the same cycle, address 0x003, data 0xAA; the next frame outputs 0xAA as the 4th byte.
- wr_req held continuously during a frame -> reads and writes alternate; the frame still completes with 6 bytes; no cycle has both enables high.
- frame_start pulsed mid-frame -> ignored: exactly 6 bytes and one frame_done.
- Assert reset while in HOLD -> on the next edge all outputs are 0, state IDLE, no frame_done; a new frame_start restarts at BASE_ADDR.
